pipe_stage_buf: RTL and testbench

//  Generic inter-stage pipeline buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core.
//  - Replaces the per-stage go/clear registers with one parametrised block.
//  - valid/ready handshake on both sides, with a 2-entry skid so in_ready is purely registered.
//  - Synchronous flush, plus a sticky halt when a halt-flagged word retires through the stage.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_stage_buf_if.sv | 12 +
 rtl/pipe_sat_cnt.sv | 25 ++
 rtl/pipe_stage_buf.sv | 117 +++++++++++
 tb/tb_pipe_stage_buf.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and MEM/WB payload layout for the pipeline stage buffers.
// The MEM/WB word packs {halt, we, rw[3:0], a[31:0], w[31:0]} from MSB to LSB.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ONE    = 2'd1,
    FULL   = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

  localparam int unsigned MEMWB_W        = 70;
  localparam int unsigned MEMWB_HALT_BIT = 69;

  localparam int unsigned MEMWB_W_LSB  = 0;
  localparam int unsigned MEMWB_A_LSB  = 32;
  localparam int unsigned MEMWB_RW_LSB = 64;
  localparam int unsigned MEMWB_WE_BIT = 68;

  function automatic logic [MEMWB_W-1:0] memwb_pack(
    input logic        halt,
    input logic        we,
    input logic [3:0]  rw,
    input logic [31:0] a,
    input logic [31:0] w
  );
    return {halt, we, rw, a, w};
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// One valid/ready/data link between two pipeline stages.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 70
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for stage performance statistics.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer with a 2-entry skid, flush and sticky halt.
// Optional stall/bubble counters are built when PIPE_PERF_EN is defined.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = MEMWB_W,
  parameter int unsigned HALT_BIT = MEMWB_HALT_BIT,
  parameter bit          HALT_EN  = 1'b1
`ifdef PIPE_PERF_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  pipe_stage_buf_if.slave          in_if,
  pipe_stage_buf_if.master         out_if,
  output logic                     halted
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
`endif
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              in_fire, out_fire, halt_hit;

  assign out_if.valid = (state_q == ONE) || (state_q == FULL);
  assign out_if.data  = main_q;
  assign in_if.ready  = in_ready_q;
  assign halted       = (state_q == HALTED);

  assign in_fire  = in_if.valid && in_ready_q;
  assign out_fire = out_if.valid && out_if.ready;
  assign halt_hit = HALT_EN && out_fire && main_q[HALT_BIT];

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (halt_hit) begin
      state_d = HALTED;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          main_d  = in_if.data;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_if.data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_if.data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // in_ready is registered from the next state so it never depends on out_ready.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: payload registers are reset too, because an idle stage must present a zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d == EMPTY) || (state_d == ONE);
    end
  end

`ifdef PIPE_PERF_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (out_if.valid && !out_if.ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (!out_if.valid && !halted),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: reset, streaming, backpressure,
// flush, halt, and (with PIPE_PERF_EN) stall counter saturation at CNT_W=4.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned DW = 70;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic halted;
`ifdef PIPE_PERF_EN
  logic [3:0] stall_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stage_buf_if #(.DATA_W(DW)) in_bus ();
  pipe_stage_buf_if #(.DATA_W(DW)) out_bus ();

  always #5 clk = ~clk;

`ifdef PIPE_PERF_EN
  pipe_stage_buf #(.DATA_W(DW), .HALT_BIT(69), .HALT_EN(1'b1), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_if      (in_bus),
    .out_if     (out_bus),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`else
  pipe_stage_buf #(.DATA_W(DW), .HALT_BIT(69), .HALT_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_bus),
    .out_if (out_bus),
    .halted (halted)
  );
`endif

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d);
    check({tag, ".valid"}, DW'(out_bus.valid), DW'(v));
    check({tag, ".data"},  out_bus.data, d);
  endtask

  logic [DW-1:0] halt_word;

  initial begin
    halt_word = memwb_pack(1'b1, 1'b1, 4'h3, 32'h0000_0010, 32'h0000_DEAD);

    // 1 Reset held 3 cycles with in_valid asserted
    rst = 1'b1; flush = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = DW'(70'h77); out_bus.ready = 1'b0;
    repeat (3) tick();
    check("rst.in_ready", DW'(in_bus.ready), DW'(0));
    expect_out("rst", 1'b0, '0);
    check("rst.halted", DW'(halted), DW'(0));
    rst = 1'b0; in_bus.valid = 1'b0;
    tick();
    check("rel.in_ready", DW'(in_bus.ready), DW'(1));
    expect_out("rel", 1'b0, '0);

    // 2 Streaming 0x1..0x8, one-cycle latency, no stall
    out_bus.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_bus.valid = 1'b1; in_bus.data = DW'(i);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, DW'(i));
      check($sformatf("stream%0d.in_ready", i), DW'(in_bus.ready), DW'(1));
    end
    in_bus.valid = 1'b0;
    tick();
    expect_out("stream.drain", 1'b0, '0);

    // 3 Backpressure: A, B held; C refused until space frees
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = DW'(70'hA);
    tick();
    expect_out("bp.a", 1'b1, DW'(70'hA));
    check("bp.a.in_ready", DW'(in_bus.ready), DW'(1));
    in_bus.data = DW'(70'hB);
    tick();
    expect_out("bp.b", 1'b1, DW'(70'hA));
    check("bp.full.in_ready", DW'(in_bus.ready), DW'(0));
    in_bus.data = DW'(70'hC);
    repeat (2) tick();
    expect_out("bp.hold", 1'b1, DW'(70'hA));
    check("bp.hold.in_ready", DW'(in_bus.ready), DW'(0));
    out_bus.ready = 1'b1;
    tick();
    expect_out("bp.rel.b", 1'b1, DW'(70'hB));
    check("bp.rel.in_ready", DW'(in_bus.ready), DW'(1));
    tick();
    expect_out("bp.rel.c", 1'b1, DW'(70'hC));
    in_bus.valid = 1'b0;
    tick();
    expect_out("bp.empty", 1'b0, '0);

    // 4 Flush while FULL with 0xD offered, then flush in ONE with a live in_fire
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = DW'(70'h1);
    tick();
    in_bus.data = DW'(70'h2);
    tick();
    check("fl.full.in_ready", DW'(in_bus.ready), DW'(0));
    in_bus.data = DW'(70'hD); flush = 1'b1;
    tick();
    expect_out("fl.full", 1'b0, '0);
    check("fl.full.in_ready", DW'(in_bus.ready), DW'(1));
    flush = 1'b0; in_bus.valid = 1'b0; out_bus.ready = 1'b1;
    tick();
    expect_out("fl.after", 1'b0, '0);
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = DW'(70'h3);
    tick();
    expect_out("fl.one.pre", 1'b1, DW'(70'h3));
    in_bus.data = DW'(70'hE); flush = 1'b1;
    tick();
    expect_out("fl.one", 1'b0, '0);
    flush = 1'b0; in_bus.valid = 1'b0;
    tick();
    expect_out("fl.one.after", 1'b0, '0);

    // 5 Halt word retires; following 0x5 is never emitted
    out_bus.ready = 1'b1;
    in_bus.valid = 1'b1; in_bus.data = halt_word;
    tick();
    expect_out("halt.word", 1'b1, halt_word);
    check("halt.pre", DW'(halted), DW'(0));
    in_bus.data = DW'(70'h5);
    tick();
    check("halt.set", DW'(halted), DW'(1));
    expect_out("halt.out", 1'b0, '0);
    check("halt.in_ready", DW'(in_bus.ready), DW'(0));
    tick();
    expect_out("halt.hold", 1'b0, '0);
    flush = 1'b1;
    tick();
    check("halt.flush", DW'(halted), DW'(1));
    expect_out("halt.flush", 1'b0, '0);
    flush = 1'b0; in_bus.valid = 1'b0; rst = 1'b1;
    tick();
    check("halt.rst", DW'(halted), DW'(0));
    check("halt.rst.in_ready", DW'(in_bus.ready), DW'(0));
    rst = 1'b0;
    tick();
    check("halt.rel.in_ready", DW'(in_bus.ready), DW'(1));
    expect_out("halt.rel", 1'b0, '0);

`ifdef PIPE_PERF_EN
    // 6 Stall counter saturates at 15 for CNT_W=4
    rst = 1'b1;
    tick();
    check("perf.rst.stall", DW'(stall_cnt), DW'(0));
    check("perf.rst.bubble", DW'(bubble_cnt), DW'(0));
    rst = 1'b0; out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = DW'(70'h9);
    tick();
    tick();
    in_bus.valid = 1'b0;
    // The second push (0x9 again) lands in skid; main still shows the first 0x9.
    check("perf.stall1", DW'(stall_cnt), DW'(1));
    repeat (4) tick();
    check("perf.stall5", DW'(stall_cnt), DW'(5));
    repeat (15) tick();
    check("perf.stall.sat", DW'(stall_cnt), DW'(15));
    expect_out("perf.held", 1'b1, DW'(70'h9));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
